lcd_hex_driver: RTL

Parametrised HD44780-class character-LCD driver that shows a DIGITS-wide hexadecimal value as ASCII characters at a configurable DDRAM position. It performs its own power-up initialisation, then rewrites the whole field on each `load` strobe, queuing at most one update while busy. It runs from the 1 ms system tick, sits between the application datapath and the LCD pins, and replaces the fixed four-nibble controller/datapath pair.

---
 rtl/lcd_hex_driver.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_hex_driver.sv
// rtl/lcd_hex_driver.sv - HD44780-class character LCD driver showing a DIGITS-wide hex value
//
// Purpose:
//   Runs the LCD power-up sequence and then writes the whole hex field on
//   each load request. At most one further update is queued while busy.
//   Optional build macro: LCD_LEADING_ZERO_BLANK_EN. When it is defined,
//   leading zero nibbles are shown as spaces and the rightmost character is
//   always a digit.
//
// Ports:
//   clk_1ms  in   1          1 ms system tick; all logic runs on its rising edge
//   reset    in   1          synchronous active-high; restarts from POWERUP
//   data     in   4*DIGITS   value to show; the top nibble is the leftmost character
//   blank    in   1          sampled with data; when 1 the frame writes spaces
//   load     in   1          single-cycle update request
//   busy     out  1          low only when idle with nothing queued
//   E        out  1          LCD enable strobe
//   RW       out  1          tied 0 (write-only)
//   RS       out  1          0 = command, 1 = data
//   DB       out  8          LCD data bus

module lcd_hex_driver #(
    parameter int         DIGITS     = 4,
    parameter logic [6:0] START_ADDR = 7'h00
) (
    input  logic                  clk_1ms,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   data,
    input  logic                  blank,
    input  logic                  load,
    output logic                  busy,
    output logic                  E,
    output logic                  RW,
    output logic                  RS,
    output logic [7:0]            DB
);

    typedef enum logic [2:0] {
        POWERUP,
        INIT,
        IDLE,
        ADDR,
        WRITE
    } state_t;

    localparam logic [4:0] POWERUP_LAST = 5'd19;
    localparam logic [3:0] LAST_DIGIT   = 4'(DIGITS - 1);

    state_t              r_state, w_state_n;
    logic [4:0]          r_cnt, w_cnt_n;          // power-up wait counter
    logic [3:0]          r_idx, w_idx_n;          // init command / data character index
    logic [2:0]          r_ph, w_ph_n;            // byte phase: 0=T0 1=T1 2=T2, 3..4 clear wait
    logic                r_pending, w_pending_n;
    logic [4*DIGITS-1:0] r_shadow, w_shadow_n;
    logic                r_blank, w_blank_n;
    logic                r_e, w_e_n;
    logic                r_rs, w_rs_n;
    logic [7:0]          r_db, w_db_n;
    logic                r_busy, w_busy_n;
    logic                w_start;

    logic [15:0][3:0]    w_nib;                   // shadow split into characters, leftmost at 0
    logic [3:0]          w_nib_sel;
    logic [7:0]          w_char;

    // Next-state logic
    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt;
        w_idx_n     = r_idx;
        w_ph_n      = r_ph;
        w_shadow_n  = r_shadow;
        w_blank_n   = r_blank;
        w_start     = 1'b0;
        // Any load outside IDLE is remembered; repeats collapse into one flag.
        w_pending_n = r_pending | (load && (r_state != IDLE));

        case (r_state)
            POWERUP: begin
                if (r_cnt == POWERUP_LAST) begin
                    w_state_n = INIT;
                    w_cnt_n   = 5'd0;
                    w_idx_n   = 4'd0;
                    w_ph_n    = 3'd0;
                end else begin
                    w_cnt_n = r_cnt + 5'd1;
                end
            end
            INIT: begin
                // The clear command (index 2) needs two extra idle cycles.
                if ((r_idx == 4'd2 && r_ph == 3'd4) || (r_idx != 4'd2 && r_ph == 3'd2)) begin
                    w_ph_n = 3'd0;
                    if (r_idx == 4'd3) begin
                        if (w_pending_n) w_start = 1'b1;
                        else             w_state_n = IDLE;
                    end else begin
                        w_idx_n = r_idx + 4'd1;
                    end
                end else begin
                    w_ph_n = r_ph + 3'd1;
                end
            end
            IDLE: begin
                if (load) w_start = 1'b1;
            end
            ADDR: begin
                if (r_ph == 3'd2) begin
                    w_state_n = WRITE;
                    w_ph_n    = 3'd0;
                    w_idx_n   = 4'd0;
                end else begin
                    w_ph_n = r_ph + 3'd1;
                end
            end
            WRITE: begin
                if (r_ph == 3'd2) begin
                    w_ph_n = 3'd0;
                    if (r_idx == LAST_DIGIT) begin
                        // A load on the final T2 is already folded into w_pending_n.
                        if (w_pending_n) w_start = 1'b1;
                        else             w_state_n = IDLE;
                    end else begin
                        w_idx_n = r_idx + 4'd1;
                    end
                end else begin
                    w_ph_n = r_ph + 3'd1;
                end
            end
            default: begin
                w_state_n = POWERUP;
                w_cnt_n   = 5'd0;
            end
        endcase

        // Frame start: capture the value shown for the whole frame.
        if (w_start) begin
            w_state_n   = ADDR;
            w_ph_n      = 3'd0;
            w_idx_n     = 4'd0;
            w_shadow_n  = data;
            w_blank_n   = blank;
            w_pending_n = 1'b0;
        end
    end

    // Character extraction from the next shadow value so the bus is registered.
    for (genvar g = 0; g < 16; g++) begin : g_nib
        if (g < DIGITS) begin : g_used
            assign w_nib[g] = w_shadow_n[4*(DIGITS-1-g) +: 4];
        end else begin : g_pad
            assign w_nib[g] = 4'h0;
        end
    end

`ifdef LCD_LEADING_ZERO_BLANK_EN
    logic [15:0] w_lz;     // bit i: characters 0..i are all zero

    always_comb begin
        logic v_acc;
        w_lz  = '0;
        v_acc = 1'b1;
        for (int i = 0; i < 16; i++) begin
            v_acc   = v_acc & (w_nib[i] == 4'h0);
            w_lz[i] = v_acc;
        end
    end
`endif

    always_comb begin
        w_nib_sel = w_nib[w_idx_n];
        if (w_nib_sel < 4'd10) w_char = 8'h30 + {4'h0, w_nib_sel};
        else                   w_char = 8'h37 + {4'h0, w_nib_sel};
`ifdef LCD_LEADING_ZERO_BLANK_EN
        if (w_lz[w_idx_n] && (w_idx_n != LAST_DIGIT)) w_char = 8'h20;
`endif
        if (w_blank_n) w_char = 8'h20;
    end

    // Output decode from the next state; E is high only in phase 1 of a byte.
    always_comb begin
        w_e_n    = 1'b0;
        w_rs_n   = r_rs;
        w_db_n   = r_db;
        w_busy_n = !((w_state_n == IDLE) && !w_pending_n);
        case (w_state_n)
            POWERUP: begin
                w_rs_n = 1'b0;
                w_db_n = 8'h00;
            end
            INIT: begin
                w_rs_n = 1'b0;
                w_e_n  = (w_ph_n == 3'd1);
                case (w_idx_n[1:0])
                    2'd0:    w_db_n = 8'h38;
                    2'd1:    w_db_n = 8'h0C;
                    2'd2:    w_db_n = 8'h01;
                    default: w_db_n = 8'h06;
                endcase
            end
            ADDR: begin
                w_rs_n = 1'b0;
                w_db_n = {1'b1, START_ADDR};
                w_e_n  = (w_ph_n == 3'd1);
            end
            WRITE: begin
                w_rs_n = 1'b1;
                w_db_n = w_char;
                w_e_n  = (w_ph_n == 3'd1);
            end
            default: begin
                w_e_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_1ms) begin
        if (reset) begin
            r_state   <= POWERUP;
            r_cnt     <= 5'd0;
            r_idx     <= 4'd0;
            r_ph      <= 3'd0;
            r_pending <= 1'b0;
            r_shadow  <= '0;
            r_blank   <= 1'b0;
            r_e       <= 1'b0;
            r_rs      <= 1'b0;
            r_db      <= 8'h00;
            r_busy    <= 1'b1;
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_idx     <= w_idx_n;
            r_ph      <= w_ph_n;
            r_pending <= w_pending_n;
            r_shadow  <= w_shadow_n;
            r_blank   <= w_blank_n;
            r_e       <= w_e_n;
            r_rs      <= w_rs_n;
            r_db      <= w_db_n;
            r_busy    <= w_busy_n;
        end
    end

    assign E    = r_e;
    assign RW   = 1'b0;
    assign RS   = r_rs;
    assign DB   = r_db;
    assign busy = r_busy;

endmodule
